sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one single-port RAM.
REQ-002 Parameter DATA_WIDTH, default 16: RAM word width.
REQ-003 Parameter ADDR_WIDTH, default 3: RAM address width.
REQ-004 Parameter MAX_HOLD, default 4: maximum consecutive grants one locked requester may take.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 req_valid  in  NUM_REQ  per-requester command valid.
REQ-008 req_wr  in  NUM_REQ  per-requester command type, 1 = write, 0 = read.
REQ-009 req_lock  in  NUM_REQ  per-requester request to keep the grant on the next transaction.
REQ-010 req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester k at slice k.
REQ-011 req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data; requester k at slice k.
REQ-012 req_ready  out  NUM_REQ  one-hot grant; handshake when valid and ready are both high at a clock edge.
REQ-013 resp_valid  out  NUM_REQ  one-hot read-data-valid strobe.
REQ-014 resp_data  out  DATA_WIDTH  read data, shared by all requesters.
REQ-015 ram_en, ram_wr  out  1 each  RAM enable and write strobe.
REQ-016 ram_addr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH: RAM address and write data.
REQ-017 ram_rdata  in  DATA_WIDTH  RAM registered output, valid the cycle after an enabled access (read-first on write).

Function
REQ-018 The block SHALL grant at most one requester per cycle; req_ready SHALL be combinational from req_valid and the arbiter state, and SHALL be 0 for requesters with req_valid low.
REQ-019 ram_en/ram_wr/ram_addr/ram_wdata SHALL be combinational copies of the granted requester's command; with no grant, ram_en = ram_wr = 0 and addr/wdata = 0.
REQ-020 Arbitration SHALL be round-robin: priority starts at (last_grant+1) mod NUM_REQ and wraps at NUM_REQ-1 -> 0; last_grant updates on every handshake.
REQ-021 FSM states: ARB, which applies round-robin selection, and HOLD, in which only the owner may be granted.
REQ-022 ARB->HOLD on a handshake with the owner's req_lock=1; hold_cnt is then loaded with 1.
REQ-023 In HOLD, each owner handshake with req_lock=1 increments hold_cnt; HOLD->ARB when req_lock=0 at the handshake, or when hold_cnt reaches MAX_HOLD, or when the owner drops req_valid.
REQ-024 In HOLD with the owner's req_valid low, no grant SHALL be issued that cycle; the FSM returns to ARB at the next edge.
REQ-025 Read latency: a read handshake at edge T SHALL raise resp_valid[k] for exactly the cycle after T, with resp_data = ram_rdata.
REQ-026 Write handshakes SHALL produce no resp_valid.
REQ-027 Back-to-back reads from any requesters SHALL be sustained at 1 per cycle.
REQ-028 resp_data SHALL be 0 whenever resp_valid is all-zero.
REQ-029 A write followed by a read of the same address in the next cycle SHALL return the new data; the block SHALL NOT add stalls.

Reset
REQ-030 While rst=1: req_ready=0, resp_valid=0, resp_data=0, ram_en=0, ram_wr=0, ram_addr=0, ram_wdata=0, state=ARB, hold_cnt=0, last_grant=NUM_REQ-1 (requester 0 highest priority after reset).
REQ-031 Reset asserted mid-operation SHALL immediately drop any pending response strobe; no response is issued after release.

Structure
REQ-032 A shared package SHALL hold the FSM state enum (ARB, HOLD) and the default-parameter constants.
REQ-033 One sub-module, sp_ram_rr_pick, SHALL hold the combinational rotate-priority selector (inputs: request vector and last_grant; output: one-hot grant); the FSM, counter and response pipeline SHALL stay in the top module.

Verification
REQ-034 Default RAM content (addr a, nibble j = j+1+a): requester 1 reads addr 2 -> the next cycle, resp_valid=4'b0010 and resp_data=16'h6543.
REQ-035 All four requesters hold valid reads after reset -> grant order 0,1,2,3,0 on consecutive cycles, with no idle cycle.
REQ-036 Requester 2 writes 16'hBEEF to addr 5, then requester 0 reads addr 5 the next cycle -> resp_data=16'hBEEF with resp_valid=4'b0001.
REQ-037 Requester 3 keeps req_lock=1 with valid held, while requester 0 is also valid -> requester 3 is granted 4 consecutive cycles, then requester 0 is granted.
REQ-038 rst pulsed the cycle after a read handshake -> resp_valid stays 0 and all outputs are 0; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/sp_ram_arbiter_pkg.sv
// Shared types and default sizing for the single-port RAM arbiter.
// Holds the arbiter FSM state encoding used by the top and the testbench.
package sp_ram_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned DEF_MAX_HOLD   = 4;

    // Index width that stays legal for a single requester
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Requester command/response bus plus the RAM port of the arbiter.
// slave = arbiter side, master = requesters/RAM side.
interface sp_ram_arbiter_if
    import sp_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ-1:0]            req_lock;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          ram_en;
    logic                          ram_wr;
    logic [ADDR_WIDTH-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]         ram_wdata;
    logic [DATA_WIDTH-1:0]         ram_rdata;

    modport slave (
        input  req_valid, req_wr, req_lock, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_data,
        output ram_en, ram_wr, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_wr, req_lock, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_data,
        input  ram_en, ram_wr, ram_addr, ram_wdata
    );

endinterface

// File: rtl/sp_ram_rr_pick.sv
// Combinational rotating-priority selector: the first requester after
// last_grant (wrapping) wins; output is one-hot or all-zero.
module sp_ram_rr_pick
    import sp_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned LGW     = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LGW-1:0]     last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic [LGW-1:0] idx;
    logic           found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = LGW'((32'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// Arbiter sharing one single-port RAM between NUM_REQ requesters:
// round-robin with optional bounded lock, 1-cycle read response pipeline.
module sp_ram_arbiter
    import sp_ram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned MAX_HOLD   = DEF_MAX_HOLD
) (
    input  logic            clk,
    input  logic            rst,
    sp_ram_arbiter_if.slave bus
);

    localparam int unsigned LGW = idx_width(NUM_REQ);
    localparam int unsigned CW  = $clog2(MAX_HOLD + 1);

    arb_state_e         state_q, state_d;
    logic [LGW-1:0]     last_grant_q;
    logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] grant;
    logic [LGW-1:0]     gnt_idx;
    logic               hs;
    logic               lock_hs;
    logic [NUM_REQ-1:0] resp_valid_q;

    sp_ram_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .LGW     (LGW)
    ) u_pick (
        .req        (bus.req_valid),
        .last_grant (last_grant_q),
        .grant      (pick_gnt)
    );

    // In HOLD the owner is always last_grant; a missing owner request yields no grant.
    always_comb begin
        grant = '0;
        if (!rst) begin
            if (state_q == ARB) begin
                grant = pick_gnt;
            end else if (bus.req_valid[last_grant_q]) begin
                grant[last_grant_q] = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = LGW'(i);
        end
    end

    assign hs      = |grant;
    assign lock_hs = hs && bus.req_lock[gnt_idx];

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ARB: begin
                if (lock_hs && (MAX_HOLD > 1)) begin
                    state_d    = HOLD;
                    hold_cnt_d = CW'(1);
                end
            end
            HOLD: begin
                if (!lock_hs || (hold_cnt_q == CW'(MAX_HOLD - 1))) begin
                    state_d    = ARB;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d    = ARB;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB;
            hold_cnt_q   <= '0;
            last_grant_q <= LGW'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            if (hs) last_grant_q <= gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) resp_valid_q <= '0;
        else     resp_valid_q <= grant & ~bus.req_wr;
    end

    assign bus.req_ready  = grant;
    assign bus.ram_en     = hs;
    assign bus.ram_wr     = hs & bus.req_wr[gnt_idx];
    assign bus.ram_addr   = hs ? bus.req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.ram_wdata  = hs ? bus.req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = (|resp_valid_q) ? bus.ram_rdata : '0;

    a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_valid  : assert property (@(posedge clk) disable iff (rst) (grant & ~bus.req_valid) == '0);

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed self-checking bench for sp_ram_arbiter with a read-first RAM model.
module tb_sp_ram_arbiter;
    import sp_ram_arbiter_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [DW-1:0] mem [2**AW];

    sp_ram_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sp_ram_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_HOLD   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_en) begin
            bus.ram_rdata <= mem[bus.ram_addr];
            if (bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic put(input int unsigned k, input logic wr, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.req_valid[k]            = 1'b1;
        bus.req_wr[k]               = wr;
        bus.req_lock[k]             = lock;
        bus.req_addr[k*AW +: AW]    = addr;
        bus.req_wdata[k*DW +: DW]   = wdata;
    endtask

    task automatic check_resp(input string tag, input logic [3:0] v, input logic [15:0] d);
        check({tag, "_rv"}, 32'(bus.resp_valid), 32'(v));
        check({tag, "_rd"}, 32'(bus.resp_data), 32'(d));
    endtask

    // Expected grants/responses for all-four-valid reads (addr k) and the lock run
    logic [3:0]  rr_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [15:0] rr_data [5] = '{16'h4321, 16'h5432, 16'h6543, 16'h7654, 16'h4321};
    logic [3:0]  lk_gnt  [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0]  lk_rv   [5] = '{4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    logic [15:0] lk_rd   [5] = '{16'h4321, 16'h7654, 16'h7654, 16'h7654, 16'h7654};

    initial begin
        for (int a = 0; a < 2**AW; a++)
            mem[a] = {4'(a + 4), 4'(a + 3), 4'(a + 2), 4'(a + 1)};
        bus.ram_rdata = '0;
        rst = 1'b1;
        clear_reqs();
        bus.req_valid = '1;
        bus.req_wr    = '1;
        bus.req_addr  = '1;
        bus.req_wdata = '1;
        cyc();
        cyc();
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check_resp("rst", 4'h0, 16'h0);
        check("rst_ram_en", 32'(bus.ram_en), 32'h0);
        check("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'h0);
        clear_reqs();
        rst = 1'b0;

        // Single read: requester 1, addr 2
        put(1, 1'b0, 1'b0, 3'd2, 16'h0);
        #1;
        check("rd1_ready", 32'(bus.req_ready), 32'h2);
        check("rd1_ram_en", 32'(bus.ram_en), 32'h1);
        check("rd1_ram_addr", 32'(bus.ram_addr), 32'h2);
        cyc();
        clear_reqs();
        #1;
        check_resp("rd1", 4'b0010, 16'h6543);
        cyc();
        check_resp("rd1_idle", 4'h0, 16'h0);

        // Round-robin from reset with all four reading
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int unsigned k = 0; k < NR; k++) put(k, 1'b0, 1'b0, AW'(k), 16'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr_ready%0d", i), 32'(bus.req_ready), 32'(rr_gnt[i]));
            cyc();
            check_resp($sformatf("rr%0d", i), rr_gnt[i], rr_data[i]);
        end
        clear_reqs();

        // Write then read the same address on the next cycle
        put(2, 1'b1, 1'b0, 3'd5, 16'hBEEF);
        #1;
        check("wr_ready", 32'(bus.req_ready), 32'h4);
        check("wr_ram_wr", 32'(bus.ram_wr), 32'h1);
        check("wr_ram_wdata", 32'(bus.ram_wdata), 32'hBEEF);
        cyc();
        clear_reqs();
        put(0, 1'b0, 1'b0, 3'd5, 16'h0);
        #1;
        check("wr_no_resp", 32'(bus.resp_valid), 32'h0);
        check("raw_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        clear_reqs();
        #1;
        check_resp("raw", 4'b0001, 16'hBEEF);

        // Locked requester 3 vs requester 0: 4 consecutive grants then 0
        put(2, 1'b0, 1'b0, 3'd0, 16'h0);
        #1;
        check("pre_lock_ready", 32'(bus.req_ready), 32'h4);
        cyc();
        clear_reqs();
        put(3, 1'b0, 1'b1, 3'd3, 16'h0);
        put(0, 1'b0, 1'b0, 3'd0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("lk_ready%0d", i), 32'(bus.req_ready), 32'(lk_gnt[i]));
            check_resp($sformatf("lk%0d", i), lk_rv[i], lk_rd[i]);
            cyc();
        end
        clear_reqs();

        // Owner drops valid in HOLD: idle cycle, then round-robin resumes
        put(1, 1'b0, 1'b1, 3'd1, 16'h0);
        #1;
        check("hd_ready0", 32'(bus.req_ready), 32'h2);
        cyc();
        clear_reqs();
        put(2, 1'b0, 1'b0, 3'd2, 16'h0);
        #1;
        check("hd_ready1", 32'(bus.req_ready), 32'h0);
        check("hd_ram_en", 32'(bus.ram_en), 32'h0);
        check_resp("hd", 4'b0010, 16'h5432);
        cyc();
        #1;
        check("hd_ready2", 32'(bus.req_ready), 32'h4);
        cyc();
        clear_reqs();

        // Reset right after a read handshake kills the pending response
        put(3, 1'b0, 1'b0, 3'd1, 16'h0);
        #1;
        check("rr3_ready", 32'(bus.req_ready), 32'h8);
        cyc();
        bus.req_valid = '1;
        rst = 1'b1;
        #1;
        check_resp("mid_rst", 4'h0, 16'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_ram_en", 32'(bus.ram_en), 32'h0);
        check("mid_rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        cyc();
        check("mid_rst_rv2", 32'(bus.resp_valid), 32'h0);
        rst = 1'b0;
        clear_reqs();
        #1;
        check("post_rst_rv", 32'(bus.resp_valid), 32'h0);
        bus.req_valid = '1;
        #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'h1);
        cyc();
        clear_reqs();
        #1;
        check_resp("post_rst", 4'b0001, 16'h4321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
